// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the Wishbone-to-SDRAM arbiter.
//   - default requester count and burst limit
//   - arbiter state encoding
//   - slice widths of the packed per-requester buses
//   - idx_width(): width of an owner index for a given requester count
package sdram_arb_pkg;

    localparam int NUM_REQ_DEF   = 3;
    localparam int MAX_BURST_DEF = 16;

    localparam int SEL_W = 4;
    localparam int ADR_W = 32;
    localparam int DAT_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_sdram_arbiter_rr_pick.sv
// Round-robin picker (purely combinational).
//   pending     : requester i wants the bus
//   last_owner  : index of the most recently released owner
//   pick_onehot : one-hot next owner, searched from last_owner+1 upward
//   pick_idx    : binary index of the same requester
//   valid       : at least one requester is pending
module rr_pick
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               valid
);

    logic [IDX_W-1:0] idx_v;

    // Walk from the farthest candidate to the nearest so the nearest
    // pending requester after last_owner is the one left standing.
    always_comb begin
        pick_onehot = '0;
        pick_idx    = '0;
        valid       = 1'b0;
        idx_v       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx_v = IDX_W'((int'(last_owner) + k) % NUM_REQ);
            if (pending[idx_v]) begin
                pick_onehot        = '0;
                pick_onehot[idx_v] = 1'b1;
                pick_idx           = idx_v;
                valid              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// Arbitrates NUM_REQ Wishbone masters onto a single SDRAM Wishbone slave.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no owner; m_wbs_* held at 0, slave acks ignored
//   OWN     | owner's bus forwarded to the slave, acks routed back to it
//
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   s_wbs_*_i / s_wbs_*_o   : requester side, packed per requester
//                             (sel 4 bits, adr/dat 32 bits per slot)
//   m_wbs_*_o / m_wbs_*_i   : SDRAM slave side
//   grant_o                 : one-hot current owner, 0 when idle
//
// An owner keeps the bus until it drops cyc, or until its MAX_BURST-th
// acked beat while someone else is waiting. One idle cycle always sits
// between two owners, so a preempted owner's pending beat is simply
// re-presented after it is granted again.
module wb_sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic [NUM_REQ-1:0]       s_wbs_cyc_i,
    input  logic [NUM_REQ-1:0]       s_wbs_stb_i,
    input  logic [NUM_REQ-1:0]       s_wbs_we_i,
    input  logic [SEL_W*NUM_REQ-1:0] s_wbs_sel_i,
    input  logic [ADR_W*NUM_REQ-1:0] s_wbs_adr_i,
    input  logic [DAT_W*NUM_REQ-1:0] s_wbs_dat_i,
    output logic [NUM_REQ-1:0]       s_wbs_ack_o,
    output logic [DAT_W-1:0]         s_wbs_dat_o,

    output logic                     m_wbs_cyc_o,
    output logic                     m_wbs_stb_o,
    output logic                     m_wbs_we_o,
    output logic [SEL_W-1:0]         m_wbs_sel_o,
    output logic [ADR_W-1:0]         m_wbs_adr_o,
    output logic [DAT_W-1:0]         m_wbs_dat_o,
    input  logic                     m_wbs_ack_i,
    input  logic [DAT_W-1:0]         m_wbs_dat_i,

    output logic [NUM_REQ-1:0]       grant_o
);

    localparam int               IDX_W     = idx_width(NUM_REQ);
    localparam int               CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] last_owner;
    logic [CNT_W-1:0] beat_cnt;

    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    logic [SEL_W-1:0] sel_arr [NUM_REQ];
    logic [ADR_W-1:0] adr_arr [NUM_REQ];
    logic [DAT_W-1:0] dat_arr [NUM_REQ];

    logic             own;
    logic             ack_own;
    logic             others_pending;
    logic [CNT_W-1:0] cnt_next;
    logic             release_bus;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign sel_arr[i] = s_wbs_sel_i[i*SEL_W +: SEL_W];
        assign adr_arr[i] = s_wbs_adr_i[i*ADR_W +: ADR_W];
        assign dat_arr[i] = s_wbs_dat_i[i*DAT_W +: DAT_W];
    end

    assign pending = s_wbs_cyc_i & s_wbs_stb_i;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .pending     (pending),
        .last_owner  (last_owner),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .valid       (pick_valid)
    );

    assign own            = (state == ST_OWN);
    assign ack_own        = own & m_wbs_ack_i;
    assign others_pending = |(pending & ~grant_o);
    // Saturates so a long solo burst can still be cut at the next ack
    // once another requester shows up.
    assign cnt_next       = (beat_cnt == BURST_MAX) ? BURST_MAX : beat_cnt + 1'b1;
    assign release_bus    = ~s_wbs_cyc_i[owner] |
                            (ack_own & (cnt_next == BURST_MAX) & others_pending);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= '0;
            last_owner <= LAST_INIT;
            beat_cnt   <= '0;
            grant_o    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state    <= ST_OWN;
                        owner    <= pick_idx;
                        grant_o  <= pick_onehot;
                        beat_cnt <= '0;
                    end
                end
                ST_OWN: begin
                    if (release_bus) begin
                        state      <= ST_IDLE;
                        grant_o    <= '0;
                        last_owner <= owner;
                    end else if (ack_own) begin
                        beat_cnt <= cnt_next;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_o <= '0;
                end
            endcase
        end
    end

    always_comb begin
        m_wbs_cyc_o = 1'b0;
        m_wbs_stb_o = 1'b0;
        m_wbs_we_o  = 1'b0;
        m_wbs_sel_o = '0;
        m_wbs_adr_o = '0;
        m_wbs_dat_o = '0;
        if (own) begin
            m_wbs_cyc_o = s_wbs_cyc_i[owner];
            m_wbs_stb_o = s_wbs_stb_i[owner];
            m_wbs_we_o  = s_wbs_we_i[owner];
            m_wbs_sel_o = sel_arr[owner];
            m_wbs_adr_o = adr_arr[owner];
            m_wbs_dat_o = dat_arr[owner];
        end
    end

    assign s_wbs_ack_o = {NUM_REQ{ack_own}} & grant_o;
    assign s_wbs_dat_o = m_wbs_dat_i;

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
module tb_wb_sdram_arbiter;

    localparam int N  = 3;
    localparam int MB = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    s_cyc, s_stb, s_we;
    logic [4*N-1:0]  s_sel;
    logic [32*N-1:0] s_adr, s_dat_w;
    logic [N-1:0]    s_ack;
    logic [31:0]     s_dat_r;
    logic            m_cyc, m_stb, m_we;
    logic [3:0]      m_sel;
    logic [31:0]     m_adr, m_dat_w;
    logic            m_ack = 1'b0;
    logic [31:0]     m_dat_r = '0;
    logic [N-1:0]    grant;

    always #5 clk = ~clk;

    wb_sdram_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .s_wbs_cyc_i (s_cyc),
        .s_wbs_stb_i (s_stb),
        .s_wbs_we_i  (s_we),
        .s_wbs_sel_i (s_sel),
        .s_wbs_adr_i (s_adr),
        .s_wbs_dat_i (s_dat_w),
        .s_wbs_ack_o (s_ack),
        .s_wbs_dat_o (s_dat_r),
        .m_wbs_cyc_o (m_cyc),
        .m_wbs_stb_o (m_stb),
        .m_wbs_we_o  (m_we),
        .m_wbs_sel_o (m_sel),
        .m_wbs_adr_o (m_adr),
        .m_wbs_dat_o (m_dat_w),
        .m_wbs_ack_i (m_ack),
        .m_wbs_dat_i (m_dat_r),
        .grant_o     (grant)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // requester-side masters
    int          r_active [N];
    int          r_total  [N];
    int          r_idx    [N];
    logic [31:0] r_base   [N];
    logic [31:0] r_dbase  [N];
    logic        r_we     [N];
    logic [3:0]  r_sel    [N];

    // scoreboard: next beat the slave should see per requester
    int exp_ptr [N];

    // slave model
    bit          slave_auto = 1'b1;
    int          max_delay  = 0;
    int          s_delay    = 0;
    bit          force_rd_en = 1'b0;
    logic [31:0] force_rd   = '0;

    // ownership history
    int           seg_owner_q[$];
    int           seg_len_q[$];
    int           seg_gap_q[$];
    logic [N-1:0] prev_grant = '0;
    int           seg_beats  = 0;
    int           idle_run   = 0;
    int           cur_gap    = 0;
    logic [N-1:0] last_s_ack = '0;
    logic [31:0]  last_s_dat = '0;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return force_rd_en ? force_rd : ((a ^ 32'h5A5A_0000) + 32'h1);
    endfunction

    function automatic int oh_idx(input logic [N-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (g[i]) r = i;
        if (!$onehot(g)) r = -1;
        return r;
    endfunction

    task automatic apply_req();
        for (int i = 0; i < N; i++) begin
            s_cyc[i]          = (r_active[i] != 0);
            s_stb[i]          = (r_active[i] != 0);
            s_we[i]           = r_we[i];
            s_sel[4*i +: 4]   = r_sel[i];
            s_adr[32*i +: 32] = r_base[i] + 32'(4 * r_idx[i]);
            s_dat_w[32*i +: 32] = r_dbase[i] + 32'(r_idx[i]);
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            r_active[i] = 0; r_total[i] = 0; r_idx[i] = 0;
            r_base[i] = '0; r_dbase[i] = '0; r_we[i] = 1'b0; r_sel[i] = 4'h0;
            exp_ptr[i] = 0;
        end
        seg_owner_q.delete(); seg_len_q.delete(); seg_gap_q.delete();
        prev_grant = '0; seg_beats = 0; idle_run = 0; cur_gap = 0;
        apply_req();
    endtask

    task automatic start_req(input int i, input int total, input logic [31:0] base,
                             input logic [31:0] dbase, input logic we);
        r_active[i] = 1; r_total[i] = total; r_idx[i] = 0;
        r_base[i] = base; r_dbase[i] = dbase; r_we[i] = we;
        r_sel[i] = 4'($urandom_range(1, 15));
        exp_ptr[i] = 0;
        apply_req();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_ack = 1'b0;
        s_delay = 0;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One bus cycle: slave acts at the falling edge, masters advance just
    // after the rising edge on which their ack was seen.
    task automatic step();
        int          idx;
        logic [31:0] ea, ed;
        @(negedge clk);
        n_cmp++;
        if (!$onehot0(grant)) begin
            n_mis++; $display("FAIL grant_onehot0: grant=%b, required at most one bit", grant);
        end
        if (grant !== prev_grant) begin
            if (prev_grant != '0) begin
                seg_owner_q.push_back(oh_idx(prev_grant));
                seg_len_q.push_back(seg_beats);
                seg_gap_q.push_back(cur_gap);
                n_cmp++;
                if (grant != '0) begin
                    n_mis++; $display("FAIL idle_gap: grant %b -> %b, required an idle cycle between", prev_grant, grant);
                end
            end
            if (grant != '0) begin cur_gap = idle_run; seg_beats = 0; end
        end
        idle_run   = (grant == '0) ? idle_run + 1 : 0;
        prev_grant = grant;

        if (slave_auto) begin
            if (m_ack) begin
                m_ack = 1'b0;
            end else if (m_cyc && m_stb) begin
                if (s_delay > 0) begin
                    s_delay--;
                end else begin
                    idx = oh_idx(grant);
                    n_cmp++;
                    if (idx < 0) begin
                        n_mis++; $display("FAIL beat_owner: grant=%b during beat, required one-hot", grant);
                    end else begin
                        n_cmp++;
                        if (exp_ptr[idx] >= r_total[idx]) begin
                            n_mis++; $display("FAIL extra_beat: req %0d beat %0d, required at most %0d", idx, exp_ptr[idx], r_total[idx]);
                        end else begin
                            ea = r_base[idx] + 32'(4 * exp_ptr[idx]);
                            ed = r_dbase[idx] + 32'(exp_ptr[idx]);
                            n_cmp++;
                            if ({m_we, m_sel, m_adr} !== {r_we[idx], r_sel[idx], ea} ||
                                (r_we[idx] && m_dat_w !== ed)) begin
                                n_mis++;
                                $display("FAIL beat_content: req %0d got we=%b sel=%h adr=%h dat=%h, required we=%b sel=%h adr=%h dat=%h",
                                         idx, m_we, m_sel, m_adr, m_dat_w, r_we[idx], r_sel[idx], ea, ed);
                            end
                        end
                        exp_ptr[idx]++;
                        seg_beats++;
                    end
                    m_ack   = 1'b1;
                    m_dat_r = m_we ? $urandom : rd_val(m_adr);
                    s_delay = $urandom_range(0, max_delay);
                end
            end
        end
        #1;
        n_cmp++;
        if (s_ack !== (m_ack ? grant : '0)) begin
            n_mis++; $display("FAIL ack_route: s_ack=%b m_ack=%b grant=%b", s_ack, m_ack, grant);
        end
        n_cmp++;
        if (s_dat_r !== m_dat_r) begin
            n_mis++; $display("FAIL dat_bcast: s_dat=%h, required %h", s_dat_r, m_dat_r);
        end
        last_s_ack = s_ack;
        last_s_dat = s_dat_r;
        for (int i = 0; i < N; i++) begin
            if (s_ack[i] && !r_we[i]) begin
                n_cmp++;
                if (s_dat_r !== rd_val(r_base[i] + 32'(4 * r_idx[i]))) begin
                    n_mis++; $display("FAIL read_data: req %0d got %h, required %h", i, s_dat_r, rd_val(r_base[i] + 32'(4 * r_idx[i])));
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (last_s_ack[i] && r_active[i] != 0) begin
                r_idx[i]++;
                if (r_idx[i] >= r_total[i]) r_active[i] = 0;
            end
        end
        apply_req();
    endtask

    task automatic run_until_done(input int budget, input string name);
        int c;
        c = 0;
        while ((r_active[0] != 0 || r_active[1] != 0 || r_active[2] != 0) && c < budget) begin
            step();
            c++;
        end
        n_cmp++;
        if (c >= budget) begin
            n_mis++; $display("FAIL %s_timeout: still busy after %0d cycles", name, c);
        end
        repeat (3) step();
    endtask

    task automatic wait_grant(input logic [N-1:0] g, input string name);
        int w;
        w = 0;
        while (grant !== g && w < 50) begin step(); w++; end
        n_cmp++;
        if (grant !== g) begin
            n_mis++; $display("FAIL %s_grant: grant=%b, required %b", name, grant, g);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_cyc = 3'b111; s_stb = 3'b111; s_we = 3'b111;
        s_sel = 12'($urandom); s_adr = {$urandom, $urandom, $urandom}; s_dat_w = {$urandom, $urandom, $urandom};
        m_ack = 1'b1; m_dat_r = $urandom;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (grant !== '0) begin n_mis++; $display("FAIL rst_grant: %b, required 000", grant); end
        n_cmp++; if ({m_cyc, m_stb, m_we} !== 3'b000) begin n_mis++; $display("FAIL rst_m_ctl: %b, required 000", {m_cyc, m_stb, m_we}); end
        n_cmp++; if ({m_sel, m_adr, m_dat_w} !== '0) begin n_mis++; $display("FAIL rst_m_bus: sel=%h adr=%h dat=%h, required 0", m_sel, m_adr, m_dat_w); end
        n_cmp++; if (s_ack !== '0) begin n_mis++; $display("FAIL rst_ack: %b, required 000", s_ack); end
        n_cmp++; if (s_dat_r !== m_dat_r) begin n_mis++; $display("FAIL rst_dat: %h, required %h", s_dat_r, m_dat_r); end
        m_ack = 1'b0;
        clear_reqs();
        rst = 1'b0;
        repeat (2) step();
        n_cmp++; if (grant !== '0) begin n_mis++; $display("FAIL idle_grant: %b with no requests, required 000", grant); end
    endtask

    task automatic test_single_write();
        do_reset();
        max_delay = 4;
        start_req(1, 50, 32'h8, 32'h0, 1'b1);
        run_until_done(1500, "single");
        n_cmp++; if (exp_ptr[1] !== 50) begin n_mis++; $display("FAIL single_beats: %0d, required 50", exp_ptr[1]); end
        n_cmp++;
        if (seg_owner_q.size() != 1 || seg_owner_q[0] != 1 || seg_len_q[0] != 50) begin
            n_mis++; $display("FAIL single_grant: %0d segments, first owner/len %0d/%0d, required one 010 segment of 50",
                              seg_owner_q.size(), seg_owner_q.size() > 0 ? seg_owner_q[0] : -1, seg_len_q.size() > 0 ? seg_len_q[0] : -1);
        end
    endtask

    task automatic test_all_three();
        do_reset();
        max_delay = $urandom_range(0, 4);
        for (int i = 0; i < N; i++)
            start_req(i, 3, 32'h1000 * (i + 1), 32'hA000 * (i + 1), 1'($urandom));
        run_until_done(500, "all3");
        n_cmp++;
        if (seg_owner_q.size() != 3) begin
            n_mis++; $display("FAIL all3_segments: %0d, required 3", seg_owner_q.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                n_cmp++;
                if (seg_owner_q[j] != j || seg_len_q[j] != 3) begin
                    n_mis++; $display("FAIL all3_order: segment %0d owner %0d len %0d, required owner %0d len 3", j, seg_owner_q[j], seg_len_q[j], j);
                end
                if (j > 0) begin
                    n_cmp++;
                    if (seg_gap_q[j] != 1) begin
                        n_mis++; $display("FAIL all3_gap: before segment %0d gap %0d, required 1", j, seg_gap_q[j]);
                    end
                end
            end
        end
    endtask

    task automatic test_preempt();
        int exp_own[3];
        int exp_len[3];
        exp_own = '{1, 0, 1};
        exp_len = '{MB, 5, 40 - MB};
        do_reset();
        max_delay = $urandom_range(0, 3);
        start_req(1, 40, 32'h100, 32'h1000, 1'b1);
        wait_grant(3'b010, "preempt");
        start_req(0, 5, 32'h200, 32'h2000, 1'($urandom));
        run_until_done(1500, "preempt");
        n_cmp++; if (exp_ptr[1] !== 40) begin n_mis++; $display("FAIL preempt_beats1: %0d, required 40", exp_ptr[1]); end
        n_cmp++; if (exp_ptr[0] !== 5)  begin n_mis++; $display("FAIL preempt_beats0: %0d, required 5", exp_ptr[0]); end
        n_cmp++;
        if (seg_owner_q.size() != 3) begin
            n_mis++; $display("FAIL preempt_segments: %0d, required 3", seg_owner_q.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                n_cmp++;
                if (seg_owner_q[j] != exp_own[j] || seg_len_q[j] != exp_len[j]) begin
                    n_mis++; $display("FAIL preempt_seg: segment %0d owner %0d len %0d, required owner %0d len %0d",
                                      j, seg_owner_q[j], seg_len_q[j], exp_own[j], exp_len[j]);
                end
                if (j > 0) begin
                    n_cmp++;
                    if (seg_gap_q[j] != 1) begin
                        n_mis++; $display("FAIL preempt_gap: before segment %0d gap %0d, required 1", j, seg_gap_q[j]);
                    end
                end
            end
        end
    endtask

    task automatic test_read();
        int acks;
        int c;
        acks = 0; c = 0;
        do_reset();
        max_delay = 2;
        force_rd_en = 1'b1; force_rd = 32'hDEADBEEF;
        start_req(2, 4, 32'h300, 32'h0, 1'b0);
        while (r_active[2] != 0 && c < 200) begin
            step();
            c++;
            if (last_s_ack != '0) begin
                acks++;
                n_cmp++; if (last_s_ack !== 3'b100) begin n_mis++; $display("FAIL read_ack: %b, required 100", last_s_ack); end
                n_cmp++; if (last_s_dat !== 32'hDEADBEEF) begin n_mis++; $display("FAIL read_dat: %h, required deadbeef", last_s_dat); end
            end
        end
        n_cmp++; if (acks != 4) begin n_mis++; $display("FAIL read_count: %0d acks, required 4", acks); end
        force_rd_en = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_drop();
        do_reset();
        slave_auto = 1'b0;
        start_req(0, 1, 32'h400, 32'h4000, 1'b1);
        wait_grant(3'b001, "drop");
        r_active[0] = 0;
        apply_req();
        #1;
        n_cmp++; if (m_cyc !== 1'b0) begin n_mis++; $display("FAIL drop_mcyc: %b, required 0", m_cyc); end
        @(posedge clk);
        #1;
        m_ack = 1'b1;
        #1;
        n_cmp++; if (grant !== '0) begin n_mis++; $display("FAIL drop_grant: %b, required 000", grant); end
        n_cmp++; if (s_ack !== '0) begin n_mis++; $display("FAIL drop_late_ack: %b, required 000", s_ack); end
        @(negedge clk);
        n_cmp++; if (s_ack !== '0 || m_cyc !== 1'b0) begin n_mis++; $display("FAIL drop_idle: s_ack=%b m_cyc=%b, required 000/0", s_ack, m_cyc); end
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        n_cmp++; if (grant !== '0) begin n_mis++; $display("FAIL drop_stay_idle: %b, required 000", grant); end
        slave_auto = 1'b1;
        clear_reqs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        max_delay = 1;
        start_req(1, 30, 32'h500, 32'h5000, 1'b1);
        wait_grant(3'b010, "rstmid");
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (grant !== '0) begin n_mis++; $display("FAIL rstmid_grant: %b, required 000", grant); end
        n_cmp++; if ({m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_w} !== '0) begin
            n_mis++; $display("FAIL rstmid_mbus: cyc=%b stb=%b we=%b sel=%h adr=%h, required all 0", m_cyc, m_stb, m_we, m_sel, m_adr);
        end
        n_cmp++; if (s_ack !== '0) begin n_mis++; $display("FAIL rstmid_ack: %b, required 000", s_ack); end
        m_ack = 1'b0; s_delay = 0;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < N; i++) start_req(i, 2, 32'h600 + 32'h100 * i, 32'h6000 * (i + 1), 1'b1);
        run_until_done(400, "rstmid");
        n_cmp++;
        if (seg_owner_q.size() < 1 || seg_owner_q[0] != 0) begin
            n_mis++; $display("FAIL rstmid_first: owner %0d, required 0", seg_owner_q.size() > 0 ? seg_owner_q[0] : -1);
        end
    endtask

    task automatic test_random();
        int st[N];
        int tot[N];
        int cum[N];
        int c;
        for (int round = 0; round < 4; round++) begin
            clear_reqs();
            max_delay = $urandom_range(0, 4);
            for (int i = 0; i < N; i++) begin
                st[i] = $urandom_range(0, 30);
                tot[i] = $urandom_range(1, 40);
                cum[i] = 0;
            end
            c = 0;
            while (c < 3000) begin
                for (int i = 0; i < N; i++)
                    if (c == st[i]) start_req(i, tot[i], 32'h10000 * (round + 1) + 32'h1000 * i, $urandom, 1'($urandom));
                if (c > 31 && r_active[0] == 0 && r_active[1] == 0 && r_active[2] == 0) break;
                step();
                c++;
            end
            n_cmp++;
            if (c >= 3000) begin n_mis++; $display("FAIL rand_timeout: round %0d", round); end
            repeat (3) step();
            for (int i = 0; i < N; i++) begin
                n_cmp++;
                if (exp_ptr[i] != tot[i]) begin
                    n_mis++; $display("FAIL rand_beats: round %0d req %0d got %0d beats, required %0d", round, i, exp_ptr[i], tot[i]);
                end
            end
            // a segment that ends before its owner is finished must have
            // lasted at least a full burst
            for (int j = 0; j < seg_owner_q.size(); j++) begin
                if (seg_owner_q[j] >= 0) begin
                    cum[seg_owner_q[j]] += seg_len_q[j];
                    if (cum[seg_owner_q[j]] < tot[seg_owner_q[j]]) begin
                        n_cmp++;
                        if (seg_len_q[j] < MB) begin
                            n_mis++; $display("FAIL rand_early_release: req %0d released after %0d beats, required >= %0d", seg_owner_q[j], seg_len_q[j], MB);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        s_cyc = '0; s_stb = '0; s_we = '0; s_sel = '0; s_adr = '0; s_dat_w = '0;
        #1 rst = 1'b1;
        test_reset();
        test_single_write();
        test_all_three();
        test_preempt();
        test_read();
        test_drop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/wb_sdram_arbiter.md
WB_SDRAM_ARBITER -- requirements
Module: wb_sdram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of Wishbone requesters (index 0 = dma_in read path, 1 = dma_out write path, 2 = CPU).
REQ-002 Parameter MAX_BURST, default 16, acked beats after which the owner is released if another requester is pending.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s_wbs_cyc_i  input  NUM_REQ  per-requester cycle.
REQ-006 s_wbs_stb_i  input  NUM_REQ  per-requester strobe.
REQ-007 s_wbs_we_i  input  NUM_REQ  per-requester write enable.
REQ-008 s_wbs_sel_i  input  4*NUM_REQ  byte selects, requester i at [4i+3:4i].
REQ-009 s_wbs_adr_i  input  32*NUM_REQ  addresses, requester i at [32i+31:32i].
REQ-010 s_wbs_dat_i  input  32*NUM_REQ  write data, same packing.
REQ-011 s_wbs_ack_o  output  NUM_REQ  per-requester acknowledge.
REQ-012 s_wbs_dat_o  output  32  read data, broadcast to all requesters.
REQ-013 m_wbs_cyc_o, m_wbs_stb_o, m_wbs_we_o  output  1 each  to SDRAM slave.
REQ-014 m_wbs_sel_o  output  4;  m_wbs_adr_o  output  32;  m_wbs_dat_o  output  32  to SDRAM slave.
REQ-015 m_wbs_ack_i  input  1;  m_wbs_dat_i  input  32  from SDRAM slave.
REQ-016 grant_o  output  NUM_REQ  one-hot current owner; all-zero when idle.

Function
REQ-017 States IDLE and OWN; owner index and beat counter are registered.
REQ-018 Requester i is pending when s_wbs_cyc_i[i] & s_wbs_stb_i[i].
REQ-019 IDLE: if any pending, next owner is chosen round-robin starting at (last_owner+1) mod NUM_REQ; go to OWN, grant_o set on that edge.
REQ-020 Grant latency: pending sampled at edge N -> m_wbs_cyc_o high after edge N; no combinational path from s_wbs_cyc_i to grant.
REQ-021 OWN: m_wbs_cyc/stb/we/sel/adr/dat_o equal owner's inputs combinationally; with no owner, all m_wbs_* outputs are 0.
REQ-022 s_wbs_ack_o[owner] = m_wbs_ack_i; all other ack bits 0; m_wbs_ack_i is ignored in IDLE.
REQ-023 s_wbs_dat_o = m_wbs_dat_i at all times.
REQ-024 Beat counter clears on grant and increments on each m_wbs_ack_i in OWN; width is clog2(MAX_BURST+1).
REQ-025 OWN -> IDLE when the owner's s_wbs_cyc_i is 0, or when the acked beat makes count == MAX_BURST and any other requester is pending.
REQ-026 On OWN -> IDLE, last_owner is updated to the owner and exactly one IDLE cycle (m_wbs_cyc_o = 0) separates two owners.
REQ-027 A preempted owner keeps cyc/stb high and sees no ack until re-granted; its pending beat is never dropped or duplicated.
REQ-028 Owner dropping cyc mid-beat (stb high, no ack yet) releases the bus; a late m_wbs_ack_i in IDLE is discarded.
REQ-029 Reaching MAX_BURST with no other requester pending keeps ownership; the counter saturates at MAX_BURST.
REQ-030 Simultaneous requests from all indices right after reset are served in order 0, 1, 2.

Reset
REQ-031 Asserting rst gives state IDLE, grant_o 0, last_owner NUM_REQ-1, beat counter 0, all m_wbs_* outputs 0, and s_wbs_ack_o 0.
REQ-032 Reset mid-transfer aborts immediately (asynchronously); after release, arbitration restarts as after power-up.

Structure
REQ-033 Package sdram_arb_pkg holds NUM_REQ, MAX_BURST defaults, the state encoding, and the packed-bus slice width constants.
REQ-034 Sub-module rr_pick (combinational: pending vector, last_owner -> one-hot next owner, valid) is instantiated once.

Verification
REQ-035 Single requester 1 writes 50 beats (data 0..49) to adr 0x08.. with random 0-4 cycle ack delay -> SDRAM sees 50 writes, in order, unaltered; grant_o stays 3'b010.
REQ-036 Requesters 0, 1 and 2 pending in the same cycle after reset -> grants 001, 010, 100 in that order, each separated by one idle cycle.
REQ-037 Requester 1 streams 40 beats while requester 0 is pending -> release after beat 16; 0 is served; 1 resumes and completes 24 more beats; there are no lost or duplicated beats.
REQ-038 Requester 2 reads with m_wbs_dat_i = 0xDEADBEEF -> s_wbs_ack_o = 3'b100 only; s_wbs_dat_o = 0xDEADBEEF.
REQ-039 Owner drops cyc before ack, then the slave acks one cycle later -> the ack is discarded; no s_wbs_ack_o bit rises; the bus returns to IDLE.
REQ-040 Assert rst during a beat of requester 1 -> all m_wbs_* outputs and grant_o are 0 within the reset cycle; after deassertion, requester 0 wins first under contention.
